// File: rtl/regbank_wr_arbiter_if.sv
// Bundle for the writeback requesters and the register-bank write port.
// With WR_FWD_EN defined it also carries the same-cycle forwarding copy of the accepted write.
interface regbank_wr_arbiter_if #(
  parameter int NUMREQ    = 2,
  parameter int NUMREGS   = 32,
  parameter int DATAWIDTH = 32
);
  localparam int AW  = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;
  localparam int IDW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;

  logic [NUMREQ-1:0]           req_valid_i;
  logic [NUMREQ-1:0]           req_ready_o;
  logic [NUMREQ-1:0]           req_lock_i;
  logic [NUMREQ*AW-1:0]        req_addr_i;
  logic [NUMREQ*DATAWIDTH-1:0] req_data_i;
  logic                        we_o;
  logic [AW-1:0]               waddr_o;
  logic [DATAWIDTH-1:0]        wdata_o;
  logic [IDW-1:0]              gnt_id_o;
  logic                        busy_o;
`ifdef WR_FWD_EN
  logic                        fwd_valid_o;
  logic [AW-1:0]               fwd_addr_o;
  logic [DATAWIDTH-1:0]        fwd_data_o;
`endif

  // Requester side / bank-port observer
  modport master (
    output req_valid_i, req_lock_i, req_addr_i, req_data_i,
    input  req_ready_o, we_o, waddr_o, wdata_o, gnt_id_o, busy_o
`ifdef WR_FWD_EN
    , input fwd_valid_o, fwd_addr_o, fwd_data_o
`endif
  );

  // Arbiter side
  modport slave (
    input  req_valid_i, req_lock_i, req_addr_i, req_data_i,
    output req_ready_o, we_o, waddr_o, wdata_o, gnt_id_o, busy_o
`ifdef WR_FWD_EN
    , output fwd_valid_o, fwd_addr_o, fwd_data_o
`endif
  );
endinterface

// File: rtl/regbank_wr_arbiter.sv
// Round-robin arbiter with lockable grants in front of the single register-bank write port.
// Optional macro WR_FWD_EN adds a combinational bypass copy of the write accepted this cycle.
module regbank_wr_arbiter #(
  parameter int NUMREQ    = 2,
  parameter int NUMREGS   = 32,
  parameter int DATAWIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               hold_i,
  regbank_wr_arbiter_if.slave bus
);
  localparam int AW  = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;
  localparam int IDW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [IDW-1:0]       ptr_q, ptr_d;

  logic [IDW:0]         pick_p0;
  logic                 gnt_vld_p0;
  logic [IDW-1:0]       gnt_idx_p0;
  logic [AW-1:0]        sel_addr_p0;
  logic [DATAWIDTH-1:0] sel_data_p0;
  logic                 sel_lock_p0;
  logic                 wr_en_p0;

  logic                 we_p1;
  logic [AW-1:0]        waddr_p1;
  logic [DATAWIDTH-1:0] wdata_p1;
  logic [IDW-1:0]       gnt_id_p1;

  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] idx);
    if (int'(idx) >= NUMREQ - 1) return '0;
    return idx + IDW'(1);
  endfunction

  // Returns {found, index} of the first valid requester at or above ptr, wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [NUMREQ-1:0] vld,
                                           input logic [IDW-1:0]    ptr);
    logic           found;
    logic [IDW-1:0] sel;
    int             j;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUMREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUMREQ) j = j - NUMREQ;
      if (!found && vld[j]) begin
        found = 1'b1;
        sel   = j[IDW-1:0];
      end
    end
    return {found, sel};
  endfunction

  // Stage p0: grant selection and operand mux
  always_comb begin
    pick_p0    = rr_pick(bus.req_valid_i, ptr_q);
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    if (rst_ni && !hold_i) begin
      if (state_q == ST_LOCKED) begin
        // The owner keeps the port even while idle; nobody else may slip in.
        gnt_vld_p0 = bus.req_valid_i[owner_q];
        gnt_idx_p0 = owner_q;
      end else begin
        gnt_vld_p0 = pick_p0[IDW];
        gnt_idx_p0 = pick_p0[IDW-1:0];
      end
    end
  end

  assign sel_addr_p0 = bus.req_addr_i[int'(gnt_idx_p0)*AW +: AW];
  assign sel_data_p0 = bus.req_data_i[int'(gnt_idx_p0)*DATAWIDTH +: DATAWIDTH];
  assign sel_lock_p0 = bus.req_lock_i[gnt_idx_p0];
  assign wr_en_p0    = gnt_vld_p0 && (sel_addr_p0 != '0);

  assign bus.req_ready_o = gnt_vld_p0 ? (NUMREQ'(1) << gnt_idx_p0) : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (gnt_vld_p0) begin
      case (state_q)
        ST_UNLOCKED: begin
          ptr_d = ptr_inc(gnt_idx_p0);
          if (sel_lock_p0) begin
            state_d = ST_LOCKED;
            owner_d = gnt_idx_p0;
          end
        end
        ST_LOCKED: begin
          // Pointer already sits one past the owner from the locking beat.
          if (!sel_lock_p0) state_d = ST_UNLOCKED;
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_UNLOCKED;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Stage p1: registered bank write port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_p1     <= 1'b0;
      waddr_p1  <= '0;
      wdata_p1  <= '0;
      gnt_id_p1 <= '0;
    end else begin
      we_p1 <= wr_en_p0;
      if (gnt_vld_p0) begin
        waddr_p1  <= sel_addr_p0;
        wdata_p1  <= sel_data_p0;
        gnt_id_p1 <= gnt_idx_p0;
      end
    end
  end

  assign bus.we_o     = we_p1;
  assign bus.waddr_o  = waddr_p1;
  assign bus.wdata_o  = wdata_p1;
  assign bus.gnt_id_o = gnt_id_p1;
  assign bus.busy_o   = (state_q == ST_LOCKED);

`ifdef WR_FWD_EN
  assign bus.fwd_valid_o = wr_en_p0;
  assign bus.fwd_addr_o  = sel_addr_p0;
  assign bus.fwd_data_o  = sel_data_p0;
`endif

`ifndef SYNTHESIS
  a_ready_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.req_ready_o));
  a_ready_needs_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((bus.req_ready_o & ~bus.req_valid_i) == '0));
`endif

endmodule

// File: doc/regbank_wr_arbiter.md
Name: regbank_wr_arbiter

Overview:
Shares the single register-bank write port between NUMREQ writeback requesters (e.g. ALU, load unit, CSR unit). It runs round-robin arbitration with per-requester valid/ready handshakes and registers the winning write onto the bank's write port. It sits between the execute/memory stages and the register bank's we/waddr/wdata inputs.

Parameters:
NUMREQ, 2, number of writeback requesters (2..8)
NUMREGS, 32, registers in the bank; address width AW = $clog2(NUMREGS)
DATAWIDTH, 32, write data width

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
hold_i  input  1  stall: no grants while high
req_valid_i  input  NUMREQ  requester r has a write pending
req_ready_o  output  NUMREQ  one-hot grant; write r accepted this cycle
req_lock_i  input  NUMREQ  requester r wants to keep the grant for its next beat
req_addr_i  input  NUMREQ*AW  flattened addresses; requester r at bits [r*AW +: AW]
req_data_i  input  NUMREQ*DATAWIDTH  flattened data; requester r at bits [r*DATAWIDTH +: DATAWIDTH]
we_o  output  1  bank write enable
waddr_o  output  AW  bank write address
wdata_o  output  DATAWIDTH  bank write data
gnt_id_o  output  $clog2(NUMREQ) (min 1)  index of the requester that owns the current we_o beat
busy_o  output  1  a lock is currently held

Behaviour:
- Reset (rst_ni low, asynchronous): we_o=0, waddr_o=0, wdata_o=0, gnt_id_o=0, busy_o=0, round-robin pointer=0, lock state=UNLOCKED. req_ready_o is 0 while reset is asserted.
- req_ready_o is combinational from req_valid_i, hold_i, the pointer and the lock state. At most one bit is high.
- A handshake (valid & ready) on requester r latches its addr/data into the output registers. we_o=1 on the next cycle for exactly one cycle. Latency is 1 cycle and throughput is one write per cycle.
- If no handshake occurs in a cycle, we_o=0 in the next cycle. waddr_o, wdata_o and gnt_id_o hold their last values.
- Address 0 is read-only: the handshake still completes (ready=1), but we_o stays 0 for that beat. gnt_id_o updates.
- hold_i=1: req_ready_o=0 for all requesters, we_o=0 next cycle, and pointer and lock state do not change.
- State machine, 2 states:
  - UNLOCKED: grant the first valid requester searching from pointer p upward, wrapping modulo NUMREQ.
    - On a grant to r, p becomes (r+1) mod NUMREQ.
    - If req_lock_i[r]=1 at the handshake, go to LOCKED(owner=r) and set busy_o=1 next cycle.
  - LOCKED(owner=r): only r can be granted. Other requesters get ready=0 even when r is idle.
    - On a handshake with req_lock_i[r]=0, return to UNLOCKED and set busy_o=0 next cycle.
    - p stays (r+1) mod NUMREQ.
    - If req_valid_i[r] is low, stay LOCKED and grant nothing.
- Fairness in UNLOCKED: a continuously valid requester is granted within NUMREQ cycles.
- Requesters keep valid, addr and data stable until ready. The arbiter does not check this.
- Reset mid-lock: returns to UNLOCKED with p=0, and any in-flight we_o beat is dropped.

Optional Feature:
WR_FWD_EN.
- Defined: adds outputs fwd_valid_o (1), fwd_addr_o (AW) and fwd_data_o (DATAWIDTH). These are combinational copies of the write being accepted this cycle, giving read-after-write bypass one cycle before we_o.
  - fwd_valid_o = handshake occurred and address != 0.
  - fwd_valid_o is 0 during reset and while hold_i=1.
- Not defined: these ports are absent. Behaviour is otherwise identical.

Test Plan:
1. Reset, then req_valid_i=2'b01, addr 5, data 0xDEADBEEF → ready[0]=1 in the same cycle; next cycle we_o=1, waddr_o=5, wdata_o=0xDEADBEEF, gnt_id_o=0; the following cycle we_o=0.
2. Both requesters valid for 4 cycles with p=0 → grants 0,1,0,1; we_o high for 4 consecutive cycles with gnt_id_o 0,1,0,1.
3. Requester 1 writes addr 0, data 0x1234 → ready[1]=1; next cycle we_o=0 and gnt_id_o=1.
4. Requester 0 has lock=1 for 3 beats then 0, while requester 1 is valid throughout → ready[1]=0 for 4 grant cycles; busy_o is high from the cycle after the first beat until the cycle after the last beat; requester 1 is granted on the next cycle.
5. Both valid, hold_i=1 for 3 cycles → no ready, we_o=0, pointer unchanged; after hold_i drops, the grant goes to the requester that was next before the hold.
6. Assert rst_ni=0 asynchronously mid-cycle while LOCKED with we_o=1 → we_o, busy_o and gnt_id_o go to 0 immediately; after release, a request from requester 1 alone is granted normally.
